cbus_arbiter: RTL

- Shares the single downstream cache bus (cbus_req_t / cbus_resp_t burst interface) among NUM_MASTERS cache-side masters, e.g. icache = master 0 and dcache = master 1.
- Grants are round-robin and transaction-granular: once granted, a master owns the bus until the beat carrying last.
- Sits between the L1 caches and the AXI bridge.

---
 rtl/cbus_pkg.sv | 30 +++
 rtl/cbus_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/cbus_pkg.sv
// Cache-bus request/response burst types shared by the L1 caches, the arbiter
// and the AXI bridge.
package cbus_pkg;

   localparam logic [7:0] MLEN1  = 8'd0;
   localparam logic [7:0] MLEN2  = 8'd1;
   localparam logic [7:0] MLEN4  = 8'd3;
   localparam logic [7:0] MLEN8  = 8'd7;
   localparam logic [7:0] MLEN16 = 8'd15;

   // 151-bit request; len encodes beats-1.
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [7:0]  strobe;
      logic [63:0] data;
   } cbus_req_t;

   // 66-bit response; ready qualifies each beat, last marks the final one.
   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Round-robin, transaction-granular arbiter sharing one downstream cache bus
// among NUM_MASTERS cache-side masters.
module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  cbus_req_t        ireqs  [NUM_MASTERS],
   output cbus_resp_t       iresps [NUM_MASTERS],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             busy,
   output logic [IDX_W-1:0] owner
);

   // Handshake: a beat transfers on a cycle where oreq.valid and oresp.ready
   // are both 1; oresp.last on such a beat ends the transaction. Masters hold
   // valid and request fields stable until they see their last beat.

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic             grant_found;
   logic [IDX_W-1:0] grant_idx;
   int               scan_sum;
   int               scan_idx;

   // First valid master at or after rr_q, wrapping modulo NUM_MASTERS.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = 0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         scan_sum = int'(rr_q) + k;
         scan_idx = (scan_sum >= NUM_MASTERS) ? scan_sum - NUM_MASTERS : scan_sum;
         if (!grant_found && ireqs[IDX_W'(scan_idx)].valid) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(scan_idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               state_d = BUSY;
               owner_d = grant_idx;
               rr_d    = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
            end
         end
         BUSY: begin
            // A dropped valid aborts the transaction just like a last beat ends it.
            if (!ireqs[owner_q].valid || (oresp.ready && oresp.last)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Live pass-through so per-beat write data and strobe add no latency.
   always_comb begin
      oreq = '0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         iresps[j] = '0;
      end
      if (state_q == BUSY) begin
         oreq = ireqs[owner_q];
         if (ireqs[owner_q].valid) begin
            iresps[owner_q] = oresp;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
      end
   end

   assign busy  = (state_q == BUSY);
   assign owner = owner_q;

endmodule
